// File: rtl/vco_fmeter_pkg.sv
`timescale 1ns/1ps
// Shared state type and default parameters for the VCO frequency meter.
package vco_fmeter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_HOLD = 2'd2
  } fm_state_t;

  localparam int DEF_GATE_CYCLES = 32'd1000;
  localparam int DEF_CNT_W       = 32'd16;
  localparam int DEF_SYNC_STAGES = 32'd2;

endpackage

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
// Synchronizes an asynchronous level into clk and emits a one-cycle pulse per rising edge.
// Latency from an input transition to edge_p is SYNC_STAGES+1 cycles.
module sync_edge_det
  import vco_fmeter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_p
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   edge_r;

  // Synchronizer shift chain followed by a registered rising-edge detector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_i};
      prev_r <= sync_r[SYNC_STAGES-1];
      edge_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
    end
  end

  assign edge_p = edge_r;

endmodule

// File: rtl/vco_freq_meter.sv
`timescale 1ns/1ps
// Gated-window frequency counter for the divided VCO clock with a valid/ready result port.
// Optional counter saturation and overflow flag when VCO_FMETER_OVF_EN is defined.
module vco_freq_meter
  import vco_fmeter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vco_div_i,
  input  logic             start_i,
  input  logic             cont_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] meas_o,
  output logic             meas_valid_o,
`ifdef VCO_FMETER_OVF_EN
  output logic             ovf_o,
`endif
  input  logic             meas_ready_i
);

  localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);

  fm_state_t         state_r, state_s;
  logic [GATE_W-1:0] gate_cnt_r, gate_cnt_s;
  logic [CNT_W-1:0]  edge_cnt_r, edge_cnt_s;
  logic [CNT_W-1:0]  meas_r, meas_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              edge_p;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(vco_div_i),
    .edge_p (edge_p)
  );

`ifdef VCO_FMETER_OVF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic ovf_flag_r, ovf_flag_s;
  logic ovf_r, ovf_s;
  logic ovf_hit_s;

  // Saturating edge count including this cycle's pulse, and the sticky flag it implies.
  always_comb begin
    if (edge_p && (edge_cnt_r == CNT_MAX)) begin
      cnt_inc_s = CNT_MAX;
      ovf_hit_s = 1'b1;
    end else begin
      cnt_inc_s = edge_cnt_r + CNT_W'(edge_p);
      ovf_hit_s = ovf_flag_r;
    end
  end
`else
  assign cnt_inc_s = edge_cnt_r + CNT_W'(edge_p);
`endif

  // Next-state, counter and result logic for IDLE/GATE/HOLD.
  always_comb begin
    state_s    = state_r;
    gate_cnt_s = gate_cnt_r;
    edge_cnt_s = edge_cnt_r;
    meas_s     = meas_r;
    valid_s    = valid_r;
`ifdef VCO_FMETER_OVF_EN
    ovf_flag_s = ovf_flag_r;
    ovf_s      = ovf_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // Counters sit at zero so entry into GATE always starts a fresh window.
        gate_cnt_s = '0;
        edge_cnt_s = '0;
`ifdef VCO_FMETER_OVF_EN
        ovf_flag_s = 1'b0;
`endif
        if (start_i || cont_i) begin
          state_s = ST_GATE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GATE: begin
        edge_cnt_s = cnt_inc_s;
`ifdef VCO_FMETER_OVF_EN
        ovf_flag_s = ovf_hit_s;
`endif
        if (gate_cnt_r == GATE_LAST) begin
          meas_s  = cnt_inc_s;
          valid_s = 1'b1;
`ifdef VCO_FMETER_OVF_EN
          ovf_s   = ovf_hit_s;
`endif
          state_s = ST_HOLD;
        end else begin
          gate_cnt_s = gate_cnt_r + GATE_ONE;
          state_s    = ST_GATE;
        end
      end
      ST_HOLD: begin
        if (meas_ready_i) begin
          valid_s    = 1'b0;
          gate_cnt_s = '0;
          edge_cnt_s = '0;
`ifdef VCO_FMETER_OVF_EN
          ovf_flag_s = 1'b0;
`endif
          if (cont_i) begin
            state_s = ST_GATE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, counter and registered-output updates with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      gate_cnt_r <= '0;
      edge_cnt_r <= '0;
      meas_r     <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
`ifdef VCO_FMETER_OVF_EN
      ovf_flag_r <= 1'b0;
      ovf_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      gate_cnt_r <= gate_cnt_s;
      edge_cnt_r <= edge_cnt_s;
      meas_r     <= meas_s;
      valid_r    <= valid_s;
      busy_r     <= busy_s;
`ifdef VCO_FMETER_OVF_EN
      ovf_flag_r <= ovf_flag_s;
      ovf_r      <= ovf_s;
`endif
    end
  end

  assign busy_o       = busy_r;
  assign meas_o       = meas_r;
  assign meas_valid_o = valid_r;
`ifdef VCO_FMETER_OVF_EN
  assign ovf_o        = ovf_r;
`endif

endmodule

// File: tb/tb_vco_freq_meter.sv
`timescale 1ns/1ps
// Directed bench for vco_freq_meter: 100 MHz clk, 100-cycle gate, plus a 4-bit counter
// instance sharing all inputs to exercise wrap (or saturation with VCO_FMETER_OVF_EN).
module tb_vco_freq_meter;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        vco_div = 1'b0;
  logic        start   = 1'b0;
  logic        cont    = 1'b0;
  logic        ready   = 1'b1;
  logic        busy, valid, busy4, valid4;
  logic [15:0] meas;
  logic [3:0]  meas4;
`ifdef VCO_FMETER_OVF_EN
  logic        ovf, ovf4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int vco_half = 20;

  always #5 clk = ~clk;

  // Divided-VCO square wave; toggles land on clk falling edges.
  initial forever begin
    #(vco_half) vco_div = ~vco_div;
  end

  vco_freq_meter #(.GATE_CYCLES(100), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vco_div_i   (vco_div),
    .start_i     (start),
    .cont_i      (cont),
    .busy_o      (busy),
    .meas_o      (meas),
    .meas_valid_o(valid),
`ifdef VCO_FMETER_OVF_EN
    .ovf_o       (ovf),
`endif
    .meas_ready_i(ready)
  );

  vco_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .vco_div_i   (vco_div),
    .start_i     (start),
    .cont_i      (cont),
    .busy_o      (busy4),
    .meas_o      (meas4),
    .meas_valid_o(valid4),
`ifdef VCO_FMETER_OVF_EN
    .ovf_o       (ovf4),
`endif
    .meas_ready_i(ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts busy cycles until valid is seen; optionally pulses start at loop index pulse_at.
  task automatic run_gate(input int pulse_at, output int busy_cnt);
    bit seen;
    seen     = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (valid) begin
        seen = 1'b1;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    if (!seen) chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  initial begin
    int          cnt;
    logic [15:0] m;
    bit          stable;

    // Reset state
    step(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_meas", 32'(meas), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_meas4", 32'(meas4), 32'd0);
`ifdef VCO_FMETER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    step(8);

    // Single shot, 40 ns input, ready high
    start = 1'b1;
    run_gate(-1, cnt);
    chk("ss_gate_len", 32'(cnt), 32'd100);
    chk("ss_meas", 32'(meas), 32'd25);
`ifdef VCO_FMETER_OVF_EN
    chk("ss_meas4_sat", 32'(meas4), 32'd15);
    chk("ss_ovf4", 32'(ovf4), 32'd1);
    chk("ss_ovf", 32'(ovf), 32'd0);
`else
    chk("ss_meas4_wrap", 32'(meas4), 32'd9);
`endif
    step(1);
    chk("ss_valid_one_cycle", 32'(valid), 32'd0);
    chk("ss_busy_after", 32'(busy), 32'd0);

    // Start pulses during GATE and HOLD are ignored
    ready = 1'b0;
    step(2);
    start = 1'b1;
    run_gate(30, cnt);
    chk("ign_gate_len", 32'(cnt), 32'd100);
    chk("ign_meas", 32'(meas), 32'd25);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      start = (i == 2);
      if (!(valid && busy && meas == 16'd25)) stable = 1'b0;
    end
    chk("ign_hold_stable", 32'(stable), 32'd1);
    ready = 1'b1;
    step(1);
    chk("ign_valid_clr", 32'(valid), 32'd0);
    chk("ign_busy_clr", 32'(busy), 32'd0);
    step(5);
    chk("ign_no_extra_valid", 32'(valid), 32'd0);
    chk("ign_no_extra_busy", 32'(busy), 32'd0);

    // Continuous mode, 80 ns input, 50 cycles of backpressure
    vco_half = 40;
    step(12);
    ready = 1'b0;
    cont  = 1'b1;
    run_gate(-1, cnt);
    chk("cont_gate1_len", 32'(cnt), 32'd100);
    m = meas;
    chk("cont_meas1_range", 32'(m == 16'd12 || m == 16'd13), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (!(valid && busy && meas == m)) stable = 1'b0;
    end
    chk("cont_hold_stable", 32'(stable), 32'd1);
    ready = 1'b1;
    step(1);
    chk("cont_xfer_valid_clr", 32'(valid), 32'd0);
    chk("cont_next_gate_busy", 32'(busy), 32'd1);
    run_gate(-1, cnt);
    chk("cont_gate2_len", 32'(cnt + 1), 32'd100);
    chk("cont_meas2_range", 32'(meas == 16'd12 || meas == 16'd13), 32'd1);
    step(1);
    chk("cont_tp_valid_clr", 32'(valid), 32'd0);
    chk("cont_tp_busy", 32'(busy), 32'd1);
    cont = 1'b0;
    run_gate(-1, cnt);
    chk("cont_drop_gate_len", 32'(cnt + 1), 32'd100);
    step(1);
    chk("cont_drop_idle", 32'(busy), 32'd0);
    chk("cont_drop_valid", 32'(valid), 32'd0);

    // Reset in the middle of a gate, then a fresh measurement
    vco_half = 20;
    step(12);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(50);
    rst_n = 1'b0;
    step(1);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_meas", 32'(meas), 32'd0);
    chk("mrst_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    step(10);
    start = 1'b1;
    run_gate(-1, cnt);
    chk("mrst_gate_len", 32'(cnt), 32'd100);
    chk("mrst_meas_fresh", 32'(meas), 32'd25);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
